// File: rtl/gg_serial_add8.sv
// Byte-serial multi-precision add/subtract with a carry held between bytes and per-word flags.
// Latency: 1 cycle from input accept to OV=1 with the result byte in a one-entry output register.
// Backpressure: IR = !OV || OR (forced low in reset); a held output freezes all outputs and the carry chain.
module gg_serial_add8 #(
  parameter int W      = 8,
  parameter int MAXLEN = 16
) (
  input  logic                      CK,
  input  logic                      RST,
  input  logic                      IV,
  output logic                      IR,
  input  logic [W-1:0]              A,
  input  logic [W-1:0]              B,
  input  logic                      CI,
  input  logic                      SUB,
  input  logic                      LAST,
  output logic                      OV,
  input  logic                      OR,
  output logic [W-1:0]              S,
  output logic                      CO,
  output logic                      OLAST,
  output logic                      VF,
  output logic                      ZF,
  output logic [$clog2(MAXLEN)-1:0] IDX,
  output logic                      ERR
);

  localparam int IW = $clog2(MAXLEN);
  localparam logic [IW-1:0] CNT_MAX = IW'(MAXLEN - 1);

  // Per-word state: carry chain, word-start flag, latched mode, byte count, zero accumulator.
  logic          c_q;
  logic          first_q;
  logic          sub_q;
  logic [IW-1:0] cnt_q;
  logic          z_q;

  logic          acc;
  logic          sub_eff;
  logic [W-1:0]  beff;
  logic          cin;
  logic [W:0]    sum;
  logic          force_last;
  logic          olast_nxt;
  logic          vf_nxt;
  logic          zf_nxt;
  logic          s_zero;

  // The input side may load the output register whenever it is empty or being drained this cycle.
  assign IR  = (!OV || OR) && !RST;
  assign acc = IV && IR;

  // Byte arithmetic: mode and carry-in come from the port on a word's first byte, else from state.
  always_comb begin
    sub_eff    = first_q ? SUB : sub_q;
    beff       = sub_eff ? ~B : B;
    cin        = first_q ? (SUB ? 1'b1 : CI) : c_q;
    sum        = {1'b0, A} + {1'b0, beff} + {{W{1'b0}}, cin};
    s_zero     = (sum[W-1:0] == '0);
    force_last = (cnt_q == CNT_MAX);
    olast_nxt  = LAST || force_last;
    vf_nxt     = olast_nxt && (A[W-1] == beff[W-1]) && (sum[W-1] != A[W-1]);
    zf_nxt     = olast_nxt && z_q && s_zero;
  end

  // Output register and word state; nothing moves while a held byte waits for OR.
  always_ff @(posedge CK) begin
    if (RST) begin
      OV      <= 1'b0;
      S       <= '0;
      CO      <= 1'b0;
      OLAST   <= 1'b0;
      VF      <= 1'b0;
      ZF      <= 1'b0;
      IDX     <= '0;
      ERR     <= 1'b0;
      c_q     <= 1'b0;
      first_q <= 1'b1;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      z_q     <= 1'b1;
    end else begin
      if (acc) begin
        OV    <= 1'b1;
        S     <= sum[W-1:0];
        CO    <= sum[W];
        OLAST <= olast_nxt;
        VF    <= vf_nxt;
        ZF    <= zf_nxt;
        IDX   <= cnt_q;
        if (first_q) sub_q <= SUB;
        if (force_last && !LAST) ERR <= 1'b1;
        if (olast_nxt) begin
          // Word closed (normally or forced by length): restart clean for the next byte.
          first_q <= 1'b1;
          cnt_q   <= '0;
          z_q     <= 1'b1;
          c_q     <= 1'b0;
        end else begin
          first_q <= 1'b0;
          cnt_q   <= cnt_q + IW'(1);
          z_q     <= z_q && s_zero;
          c_q     <= sum[W];
        end
      end else if (OR) begin
        OV <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gg_serial_add8.sv
// Directed bench for gg_serial_add8: adds, subtracts, flags, backpressure, length error, reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the falling edge.
// Every expected value below is a hand-computed constant from the operand bytes.
module tb_gg_serial_add8;

  logic       CK = 1'b0;
  logic       RST, IV, CI, SUB, LAST, OR;
  logic [7:0] A, B;
  logic       IR, OV, CO, OLAST, VF, ZF, ERR;
  logic [7:0] S;
  logic [3:0] IDX;

  int n_cmp = 0;
  int n_err = 0;

  gg_serial_add8 #(.W(8), .MAXLEN(16)) dut (
    .CK(CK), .RST(RST), .IV(IV), .IR(IR), .A(A), .B(B), .CI(CI), .SUB(SUB),
    .LAST(LAST), .OV(OV), .OR(OR), .S(S), .CO(CO), .OLAST(OLAST), .VF(VF),
    .ZF(ZF), .IDX(IDX), .ERR(ERR)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until accepted; returns at the falling edge after the accept.
  task automatic put(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic sub, input logic last);
    int n;
    A = a; B = b; CI = ci; SUB = sub; LAST = last; IV = 1'b1;
    #1;
    n = 0;
    while (!IR && n < 20) begin
      @(negedge CK); #1;
      n++;
    end
    if (!IR) check("put_timeout", 32'd0, 32'd1);
    @(negedge CK);
    IV = 1'b0;
    #1;
  endtask

  logic [7:0] bp_a [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] bp_b [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
  logic       bp_or [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    int send_i, recv_i;
    logic prev_acc, prev_hold;
    logic [7:0] held_s;
    logic held_co;
    logic [3:0] held_idx;

    RST = 1'b1; IV = 1'b0; A = '0; B = '0; CI = 1'b0; SUB = 1'b0; LAST = 1'b0; OR = 1'b1;
    @(negedge CK); #1;
    check("rst_ir", IR, 0);
    @(negedge CK); #1;
    check("rst_ov", OV, 0);
    check("rst_s", S, 0);
    check("rst_idx", IDX, 0);
    check("rst_err", ERR, 0);
    RST = 1'b0;

    // 0x12FF + 0x0001
    put(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    check("add0_ov", OV, 1);
    check("add0_s", S, 8'h00);
    check("add0_co", CO, 1);
    check("add0_idx", IDX, 0);
    check("add0_olast", OLAST, 0);
    put(8'h12, 8'h00, 1'b0, 1'b0, 1'b1);
    check("add1_s", S, 8'h13);
    check("add1_co", CO, 0);
    check("add1_idx", IDX, 1);
    check("add1_olast", OLAST, 1);
    check("add1_vf", VF, 0);
    check("add1_zf", ZF, 0);

    // 0x0100 - 0x0001; CI/SUB on the second byte must be ignored
    put(8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
    check("sub0_s", S, 8'hFF);
    check("sub0_co", CO, 0);
    put(8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    check("sub1_s", S, 8'h00);
    check("sub1_co", CO, 1);
    check("sub1_zf", ZF, 0);

    // Single-byte words: signed overflow and zero
    put(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    check("ovf_s", S, 8'h80);
    check("ovf_vf", VF, 1);
    check("ovf_zf", ZF, 0);
    put(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    check("zero_s", S, 8'h00);
    check("zero_co", CO, 1);
    check("zero_zf", ZF, 1);
    check("zero_vf", VF, 0);

    // Drain, then 0xFFFFFFFF + 0x00000001 with OR pattern 1,0,0 repeating
    @(negedge CK); #1;
    check("drain_ov", OV, 0);
    send_i = 0; recv_i = 0; prev_acc = 1'b0; prev_hold = 1'b0;
    held_s = '0; held_co = 1'b0; held_idx = '0;
    for (int cyc = 0; cyc < 40 && recv_i < 4; cyc++) begin
      @(negedge CK);
      if (prev_acc) send_i++;
      if (prev_hold) begin
        check("bp_hold_s", S, held_s);
        check("bp_hold_co", CO, held_co);
        check("bp_hold_idx", IDX, held_idx);
      end
      OR = bp_or[cyc % 3];
      IV = (send_i < 4);
      if (send_i < 4) begin
        A = bp_a[send_i]; B = bp_b[send_i];
        CI = 1'b0; SUB = 1'b0; LAST = (send_i == 3);
      end
      #1;
      prev_acc  = IV && IR;
      prev_hold = OV && !OR;
      if (OV && OR) begin
        check("bp_s", S, 8'h00);
        check("bp_co", CO, 1);
        check("bp_idx", IDX, recv_i);
        check("bp_olast", OLAST, (recv_i == 3));
        if (recv_i == 3) check("bp_zf", ZF, 1);
        recv_i++;
      end
      if (OV && !OR) begin
        check("bp_ir_low", IR, 0);
        held_s = S; held_co = CO; held_idx = IDX;
      end
    end
    check("bp_recv_count", recv_i, 4);
    check("bp_send_count", send_i + (prev_acc ? 1 : 0), 4);
    IV = 1'b0; OR = 1'b1;
    @(negedge CK); #1;

    // Length error: 17 bytes without LAST; byte 16 opens a new word with CI=1
    for (int i = 0; i < 17; i++) begin
      put(8'h00, 8'h00, (i == 16), 1'b0, 1'b0);
      check("len_idx", IDX, (i == 16) ? 0 : i);
      if (i == 14) check("len_err_before", ERR, 0);
      if (i == 15) begin
        check("len_olast15", OLAST, 1);
        check("len_err15", ERR, 1);
        check("len_zf15", ZF, 1);
      end
      if (i == 16) begin
        check("len_s16", S, 8'h01);
        check("len_olast16", OLAST, 0);
        check("len_err16", ERR, 1);
      end
    end

    // Reset mid-word (that word was left open by byte 16 above, then another byte)
    put(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    check("mid_ov", OV, 1);
    RST = 1'b1;
    #1;
    check("mid_rst_ir", IR, 0);
    @(negedge CK);
    RST = 1'b0;
    #1;
    check("mid_ov_after", OV, 0);
    check("mid_err_after", ERR, 0);
    put(8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
    check("mid_s", S, 8'h08);
    check("mid_idx", IDX, 0);
    check("mid_co", CO, 0);
    check("mid_olast", OLAST, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
